// File: rtl/rv_fetch_pkg.sv
// Shared constants for the RV instruction-fetch stage and the decode/control logic.
// State encodings, NOP, instruction field positions and base opcodes.
package rv_fetch_pkg;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_REQ  = 3'd1;
  localparam logic [2:0] ST_WAIT = 3'd2;
  localparam logic [2:0] ST_HOLD = 3'd3;
  localparam logic [2:0] ST_ERR  = 3'd4;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam int unsigned OPCODE_LSB = 0;
  localparam int unsigned OPCODE_MSB = 6;
  localparam int unsigned RD_LSB     = 7;
  localparam int unsigned RD_MSB     = 11;
  localparam int unsigned FUNCT3_LSB = 12;
  localparam int unsigned FUNCT3_MSB = 14;
  localparam int unsigned RS1_LSB    = 15;
  localparam int unsigned RS1_MSB    = 19;
  localparam int unsigned RS2_LSB    = 20;
  localparam int unsigned RS2_MSB    = 24;
  localparam int unsigned FUNCT7_LSB = 25;
  localparam int unsigned FUNCT7_MSB = 31;

  localparam logic [6:0] OPC_LOAD   = 7'b000_0011;
  localparam logic [6:0] OPC_OP_IMM = 7'b001_0011;
  localparam logic [6:0] OPC_AUIPC  = 7'b001_0111;
  localparam logic [6:0] OPC_STORE  = 7'b010_0011;
  localparam logic [6:0] OPC_OP     = 7'b011_0011;
  localparam logic [6:0] OPC_LUI    = 7'b011_0111;
  localparam logic [6:0] OPC_BRANCH = 7'b110_0011;
  localparam logic [6:0] OPC_JALR   = 7'b110_0111;
  localparam logic [6:0] OPC_JAL    = 7'b110_1111;
  localparam logic [6:0] OPC_SYSTEM = 7'b111_0011;

  function automatic logic is_misaligned(input logic [1:0] lsbs);
    return lsbs != 2'b00;
  endfunction

endpackage

// File: rtl/rv_fetch_skid.sv
// One-entry {pc, instr} holding register used when a fetch response arrives
// while the output slot is still stalled. Clear wins over load, load over unload.
module rv_fetch_skid
  import rv_fetch_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            unload,
  input  logic            clear,
  input  logic [XLEN-1:0] load_pc,
  input  logic [31:0]     load_instr,
  output logic            valid,
  output logic [XLEN-1:0] pc,
  output logic [31:0]     instr
);

  logic            valid_q;
  logic [XLEN-1:0] pc_q;
  logic [31:0]     instr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      instr_q <= NOP_INSTR;
    end else if (clear) begin
      valid_q <= 1'b0;
    end else if (load) begin
      valid_q <= 1'b1;
      pc_q    <= load_pc;
      instr_q <= load_instr;
    end else if (unload) begin
      valid_q <= 1'b0;
    end
  end

  assign valid = valid_q;
  assign pc    = pc_q;
  assign instr = instr_q;

endmodule

// File: rtl/rv_fetch_stage.sv
// Instruction-fetch stage and IF/ID register: one outstanding imem request, redirect
// flush, stall skid. Optional misaligned-redirect trap via FETCH_MISALIGN_CHK_EN.
module rv_fetch_stage
  import rv_fetch_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            stall,
  output logic            if_valid,
  output logic [XLEN-1:0] if_pc,
  output logic [31:0]     if_instr,
  output logic [6:0]      opcode,
  output logic [2:0]      funct3,
  output logic [6:0]      funct7,
  output logic [4:0]      rd,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic            fetch_err
);

  localparam logic [XLEN-1:0] WORD_MASK = ~XLEN'(3);

  logic [2:0]      state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            drop_q, drop_d;
  logic            if_valid_q, if_valid_d;
  logic [XLEN-1:0] if_pc_q, if_pc_d;
  logic [31:0]     if_instr_q, if_instr_d;

  logic            skid_load, skid_unload, skid_clear, skid_valid;
  logic [XLEN-1:0] skid_pc;
  logic [31:0]     skid_instr;

  rv_fetch_skid #(
    .XLEN(XLEN)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (skid_load),
    .unload    (skid_unload),
    .clear     (skid_clear),
    .load_pc   (pc_q),
    .load_instr(imem_rdata),
    .valid     (skid_valid),
    .pc        (skid_pc),
    .instr     (skid_instr)
  );

`ifdef FETCH_MISALIGN_CHK_EN
  logic err_q, err_d;
  logic redirect_bad;
  assign redirect_bad = is_misaligned(redirect_pc[1:0]);
`endif

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    drop_d      = drop_q;
    if_valid_d  = if_valid_q;
    if_pc_d     = if_pc_q;
    if_instr_d  = if_instr_q;
    skid_load   = 1'b0;
    skid_unload = 1'b0;
    skid_clear  = 1'b0;
`ifdef FETCH_MISALIGN_CHK_EN
    err_d       = err_q;
`endif

    if (redirect && (state_q != ST_ERR)) begin
      if_valid_d = 1'b0;
      skid_clear = 1'b1;
      // A response landing in the redirect cycle is consumed here, so nothing is left in flight.
      unique case (state_q)
        ST_WAIT: drop_d = !imem_rvalid;
        ST_REQ:  drop_d = drop_q || imem_ready;
        default: drop_d = drop_q;
      endcase
`ifdef FETCH_MISALIGN_CHK_EN
      if (redirect_bad) begin
        err_d   = 1'b1;
        drop_d  = 1'b0;
        state_d = ST_ERR;
      end else begin
        pc_d    = redirect_pc;
        state_d = ST_REQ;
      end
`else
      pc_d    = redirect_pc & WORD_MASK;
      state_d = ST_REQ;
`endif
    end else begin
      if (if_valid_q && !stall) begin
        if_valid_d = 1'b0;
      end
      unique case (state_q)
        ST_IDLE: state_d = ST_REQ;
        ST_REQ: begin
          if (imem_ready) begin
            state_d = ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (imem_rvalid) begin
            state_d = ST_REQ;
            if (drop_q) begin
              drop_d = 1'b0;
            end else if (!if_valid_q || !stall) begin
              if_valid_d = 1'b1;
              if_pc_d    = pc_q;
              if_instr_d = imem_rdata;
              pc_d       = pc_q + XLEN'(4);
            end else begin
              skid_load = 1'b1;
              pc_d      = pc_q + XLEN'(4);
              state_d   = ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (!stall && skid_valid) begin
            if_valid_d  = 1'b1;
            if_pc_d     = skid_pc;
            if_instr_d  = skid_instr;
            skid_unload = 1'b1;
            state_d     = ST_REQ;
          end
        end
        ST_ERR: if_valid_d = 1'b0;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      pc_q       <= RESET_PC;
      drop_q     <= 1'b0;
      if_valid_q <= 1'b0;
      if_pc_q    <= '0;
      if_instr_q <= NOP_INSTR;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      drop_q     <= drop_d;
      if_valid_q <= if_valid_d;
      if_pc_q    <= if_pc_d;
      if_instr_q <= if_instr_d;
    end
  end

`ifdef FETCH_MISALIGN_CHK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end
  assign fetch_err = err_q;
`else
  assign fetch_err = 1'b0;
`endif

  assign imem_req  = (state_q == ST_REQ);
  assign imem_addr = pc_q & WORD_MASK;

  assign if_valid = if_valid_q;
  assign if_pc    = if_pc_q;
  assign if_instr = if_instr_q;

  assign opcode = if_instr_q[OPCODE_MSB:OPCODE_LSB];
  assign funct3 = if_instr_q[FUNCT3_MSB:FUNCT3_LSB];
  assign funct7 = if_instr_q[FUNCT7_MSB:FUNCT7_LSB];
  assign rd     = if_instr_q[RD_MSB:RD_LSB];
  assign rs1    = if_instr_q[RS1_MSB:RS1_LSB];
  assign rs2    = if_instr_q[RS2_MSB:RS2_LSB];

endmodule

// File: tb/tb_rv_fetch_stage.sv
// Directed, table-driven bench for rv_fetch_stage; one vector per clock cycle.
// Misaligned-redirect expectations follow FETCH_MISALIGN_CHK_EN.
module tb_rv_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic        fetch_err;

  always #5 clk = ~clk;

  rv_fetch_stage #(
    .XLEN    (32),
    .RESET_PC(32'h0000_0000)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_rvalid(imem_rvalid),
    .imem_rdata (imem_rdata),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .stall      (stall),
    .if_valid   (if_valid),
    .if_pc      (if_pc),
    .if_instr   (if_instr),
    .opcode     (opcode),
    .funct3     (funct3),
    .funct7     (funct7),
    .rd         (rd),
    .rs1        (rs1),
    .rs2        (rs2),
    .fetch_err  (fetch_err)
  );

  typedef struct {
    logic        ready;
    logic        rvalid;
    logic [31:0] rdata;
    logic        redir;
    logic [31:0] rpc;
    logic        stl;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic add(input logic ready, input logic rvalid, input logic [31:0] rdata,
                     input logic redir, input logic [31:0] rpc, input logic stl,
                     input logic e_req, input logic [31:0] e_addr, input logic e_valid,
                     input logic [31:0] e_pc, input logic [31:0] e_instr);
    vec_t v;
    v.ready = ready; v.rvalid = rvalid; v.rdata = rdata; v.redir = redir; v.rpc = rpc;
    v.stl = stl; v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid; v.e_pc = e_pc;
    v.e_instr = e_instr;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic ready, input logic rvalid, input logic [31:0] rdata,
                       input logic redir, input logic [31:0] rpc, input logic stl);
    imem_ready  = ready;
    imem_rvalid = rvalid;
    imem_rdata  = rdata;
    redirect    = redir;
    redirect_pc = rpc;
    stall       = stl;
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t v;
    //  rdy rv  rdata         rd  rpc           st   req addr          vld if_pc         instr
    add(0, 0, 32'h0,        0, 32'h0,        0,  1, 32'h0,        0, 32'h0,        32'h00000013);
    add(1, 0, 32'h0,        0, 32'h0,        0,  0, 32'h0,        0, 32'h0,        32'h00000013);
    add(0, 1, 32'h00500093, 0, 32'h0,        0,  1, 32'h4,        1, 32'h0,        32'h00500093);
    add(1, 0, 32'h0,        0, 32'h0,        1,  0, 32'h4,        1, 32'h0,        32'h00500093);
    add(0, 1, 32'h002081B3, 0, 32'h0,        1,  0, 32'h8,        1, 32'h0,        32'h00500093);
    add(0, 0, 32'h0,        0, 32'h0,        1,  0, 32'h8,        1, 32'h0,        32'h00500093);
    add(0, 0, 32'h0,        0, 32'h0,        0,  1, 32'h8,        1, 32'h4,        32'h002081B3);
    add(1, 0, 32'h0,        0, 32'h0,        0,  0, 32'h8,        0, 32'h4,        32'h002081B3);
    add(0, 0, 32'h0,        1, 32'h100,      0,  1, 32'h100,      0, 32'h4,        32'h002081B3);
    add(1, 0, 32'h0,        0, 32'h0,        0,  0, 32'h100,      0, 32'h4,        32'h002081B3);
    add(0, 1, 32'h00C00213, 0, 32'h0,        0,  1, 32'h100,      0, 32'h4,        32'h002081B3);
    add(1, 0, 32'h0,        0, 32'h0,        0,  0, 32'h100,      0, 32'h4,        32'h002081B3);
    add(0, 1, 32'h00A00293, 0, 32'h0,        0,  1, 32'h104,      1, 32'h100,      32'h00A00293);
    add(1, 0, 32'h0,        0, 32'h0,        1,  0, 32'h104,      1, 32'h100,      32'h00A00293);
    add(0, 1, 32'h40208333, 0, 32'h0,        1,  0, 32'h108,      1, 32'h100,      32'h00A00293);
    add(0, 0, 32'h0,        1, 32'h200,      1,  1, 32'h200,      0, 32'h100,      32'h00A00293);
    add(1, 0, 32'h0,        0, 32'h0,        0,  0, 32'h200,      0, 32'h100,      32'h00A00293);
    add(0, 1, 32'h00100513, 0, 32'h0,        0,  1, 32'h204,      1, 32'h200,      32'h00100513);
    add(1, 0, 32'h0,        0, 32'h0,        0,  0, 32'h204,      0, 32'h200,      32'h00100513);
    add(0, 1, 32'hFFFFFFFF, 1, 32'h300,      0,  1, 32'h300,      0, 32'h200,      32'h00100513);
    add(1, 0, 32'h0,        0, 32'h0,        0,  0, 32'h300,      0, 32'h200,      32'h00100513);
    add(0, 1, 32'h00300593, 0, 32'h0,        0,  1, 32'h304,      1, 32'h300,      32'h00300593);
    add(1, 0, 32'h0,        1, 32'h400,      0,  1, 32'h400,      0, 32'h300,      32'h00300593);
    add(1, 0, 32'h0,        0, 32'h0,        0,  0, 32'h400,      0, 32'h300,      32'h00300593);
    add(0, 1, 32'h11111111, 0, 32'h0,        0,  1, 32'h400,      0, 32'h300,      32'h00300593);
    add(1, 0, 32'h0,        0, 32'h0,        0,  0, 32'h400,      0, 32'h300,      32'h00300593);
    add(0, 1, 32'h00400613, 0, 32'h0,        0,  1, 32'h404,      1, 32'h400,      32'h00400613);
    add(0, 0, 32'h0,        0, 32'h0,        0,  1, 32'h404,      0, 32'h400,      32'h00400613);
    add(1, 0, 32'h0,        0, 32'h0,        0,  0, 32'h404,      0, 32'h400,      32'h00400613);
    add(0, 1, 32'h00500693, 0, 32'h0,        0,  1, 32'h408,      1, 32'h404,      32'h00500693);
    add(0, 0, 32'h0,        1, 32'hFFFFFFFC, 0,  1, 32'hFFFFFFFC, 0, 32'h404,      32'h00500693);
    add(1, 0, 32'h0,        0, 32'h0,        0,  0, 32'hFFFFFFFC, 0, 32'h404,      32'h00500693);
    add(0, 1, 32'h00000013, 0, 32'h0,        0,  1, 32'h0,        1, 32'hFFFFFFFC, 32'h00000013);
    add(1, 0, 32'h0,        0, 32'h0,        0,  0, 32'h0,        0, 32'hFFFFFFFC, 32'h00000013);

    rst_n = 1'b0;
    imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    redirect = 1'b0; redirect_pc = '0; stall = 1'b0;
    @(posedge clk);
    #1;
    check("rst_req", 32'(imem_req), 32'h0);
    check("rst_valid", 32'(if_valid), 32'h0);
    check("rst_instr", if_instr, 32'h00000013);
    check("rst_if_pc", if_pc, 32'h0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_err", 32'(fetch_err), 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      drive(v.ready, v.rvalid, v.rdata, v.redir, v.rpc, v.stl);
      check($sformatf("v%0d_req", i), 32'(imem_req), 32'(v.e_req));
      check($sformatf("v%0d_addr", i), imem_addr, v.e_addr);
      check($sformatf("v%0d_valid", i), 32'(if_valid), 32'(v.e_valid));
      check($sformatf("v%0d_if_pc", i), if_pc, v.e_pc);
      check($sformatf("v%0d_instr", i), if_instr, v.e_instr);
      check($sformatf("v%0d_opcode", i), 32'(opcode), 32'(v.e_instr[6:0]));
      check($sformatf("v%0d_rd", i), 32'(rd), 32'(v.e_instr[11:7]));
      check($sformatf("v%0d_funct3", i), 32'(funct3), 32'(v.e_instr[14:12]));
      check($sformatf("v%0d_rs1", i), 32'(rs1), 32'(v.e_instr[19:15]));
      check($sformatf("v%0d_rs2", i), 32'(rs2), 32'(v.e_instr[24:20]));
      check($sformatf("v%0d_funct7", i), 32'(funct7), 32'(v.e_instr[31:25]));
      check($sformatf("v%0d_err", i), 32'(fetch_err), 32'h0);
      if (i == 2) begin
        check("addi_opcode", 32'(opcode), 32'b0010011);
        check("addi_rd", 32'(rd), 32'd1);
        check("addi_rs1", 32'(rs1), 32'd0);
      end
      if (i == 6) begin
        check("add_opcode", 32'(opcode), 32'b0110011);
        check("add_funct7", 32'(funct7), 32'd0);
        check("add_rd", 32'(rd), 32'd3);
      end
    end

    // DUT is now in WAIT; reset asynchronously away from the clock edge.
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_req", 32'(imem_req), 32'h0);
    check("mid_rst_valid", 32'(if_valid), 32'h0);
    check("mid_rst_instr", if_instr, 32'h00000013);
    check("mid_rst_if_pc", if_pc, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("idle_req", 32'(imem_req), 32'h0);
    drive(0, 0, 32'h0, 0, 32'h0, 0);
    check("post_rst_req", 32'(imem_req), 32'h1);
    check("post_rst_addr", imem_addr, 32'h0);

    drive(0, 0, 32'h0, 1, 32'h102, 0);
`ifdef FETCH_MISALIGN_CHK_EN
    check("mis_err", 32'(fetch_err), 32'h1);
    check("mis_valid", 32'(if_valid), 32'h0);
    for (int c = 0; c < 20; c++) begin
      check($sformatf("mis_req_c%0d", c), 32'(imem_req), 32'h0);
      drive(1, 0, 32'h0, 1, 32'h200, 0);
    end
    check("mis_err_sticky", 32'(fetch_err), 32'h1);
`else
    check("mis_err", 32'(fetch_err), 32'h0);
    check("mis_req", 32'(imem_req), 32'h1);
    check("mis_addr", imem_addr, 32'h100);
    drive(1, 0, 32'h0, 0, 32'h0, 0);
    drive(0, 1, 32'h00700713, 0, 32'h0, 0);
    check("mis_if_pc", if_pc, 32'h100);
    check("mis_instr", if_instr, 32'h00700713);
    check("mis_next_addr", imem_addr, 32'h104);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
